ps2_scancode_decoder: RTL and testbench

Consumes raw Set-2 scan codes popped from the PS/2 keyboard controller's receive FIFO and turns them into registered key events. Each event carries make/break, extended flag, raw code, modifier state and an ASCII translation. Sits between the PS/2 controller and the CPU-side keyboard port. Optionally drives the controller's send path to update the Caps Lock LED.

---
 rtl/ps2_scancode_decoder_if.sv | 33 +++
 rtl/ps2_scancode_decoder.sv | 240 ++++++++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scancode_decoder_if.sv
// Keyboard-side FIFO/send signals and CPU-side key event signals of the scan code decoder.
// slave is the decoder's view; master is the view of whatever drives the decoder.
interface ps2_scancode_decoder_if;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_read;
  logic       kb_send;
  logic [7:0] kb_senddata;
  logic       key_valid;
  logic       key_ack;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [7:0] key_ascii;
  logic       shift;
  logic       ctrl;
  logic       alt;
  logic       caps;

  modport slave (
    input  kb_data, kb_ready, key_ack,
    output kb_read, kb_send, kb_senddata,
    output key_valid, key_code, key_ext, key_break, key_ascii,
    output shift, ctrl, alt, caps
  );

  modport master (
    output kb_data, kb_ready, key_ack,
    input  kb_read, kb_send, kb_senddata,
    input  key_valid, key_code, key_ext, key_break, key_ascii,
    input  shift, ctrl, alt, caps
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan code decoder: one FIFO byte per cycle into a registered key event (valid the cycle after kb_read),
// no pop while an event is unacknowledged; define CAPS_LED_EN to drive the Caps Lock LED update sequence.
module ps2_scancode_decoder
`ifdef CAPS_LED_EN
  #(parameter logic [23:0] ACK_TIMEOUT = 24'd2500000)
`endif
  (
  input logic                   clk,
  input logic                   rst,
  ps2_scancode_decoder_if.slave bus
);

`ifdef CAPS_LED_EN
  typedef enum logic [2:0] {IDLE, SKIP_E1, LED_CMD, LED_WAIT1, LED_DATA, LED_WAIT2} state_t;
`else
  typedef enum logic {IDLE, SKIP_E1} state_t;
`endif

  state_t     r_state, w_state_nxt;
  logic       r_pend_brk, r_pend_ext;
  logic [2:0] r_skip_cnt;
  logic       r_key_valid, r_key_ext, r_key_break;
  logic [7:0] r_key_code, r_key_ascii;
  logic       r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt;
  logic       r_caps, r_caps_down;

  logic       w_can_pop, w_pop, w_event, w_set_brk, w_set_ext, w_clr_pend;
  logic       w_shift, w_ctrl, w_alt;
  logic [7:0] w_letter, w_ascii;
  logic [15:0] w_sym;

  function automatic logic [7:0] f_letter(input logic [7:0] c);
    case (c)
      8'h1C: f_letter = 8'h61; 8'h32: f_letter = 8'h62; 8'h21: f_letter = 8'h63;
      8'h23: f_letter = 8'h64; 8'h24: f_letter = 8'h65; 8'h2B: f_letter = 8'h66;
      8'h34: f_letter = 8'h67; 8'h33: f_letter = 8'h68; 8'h43: f_letter = 8'h69;
      8'h3B: f_letter = 8'h6A; 8'h42: f_letter = 8'h6B; 8'h4B: f_letter = 8'h6C;
      8'h3A: f_letter = 8'h6D; 8'h31: f_letter = 8'h6E; 8'h44: f_letter = 8'h6F;
      8'h4D: f_letter = 8'h70; 8'h15: f_letter = 8'h71; 8'h2D: f_letter = 8'h72;
      8'h1B: f_letter = 8'h73; 8'h2C: f_letter = 8'h74; 8'h3C: f_letter = 8'h75;
      8'h2A: f_letter = 8'h76; 8'h1D: f_letter = 8'h77; 8'h22: f_letter = 8'h78;
      8'h35: f_letter = 8'h79; 8'h1A: f_letter = 8'h7A;
      default: f_letter = 8'h00;
    endcase
  endfunction

  // {unshifted, shifted} for digits, punctuation and control keys
  function automatic logic [15:0] f_symbol(input logic [7:0] c);
    case (c)
      8'h0E: f_symbol = 16'h607E; 8'h16: f_symbol = 16'h3121; 8'h1E: f_symbol = 16'h3240;
      8'h26: f_symbol = 16'h3323; 8'h25: f_symbol = 16'h3424; 8'h2E: f_symbol = 16'h3525;
      8'h36: f_symbol = 16'h365E; 8'h3D: f_symbol = 16'h3726; 8'h3E: f_symbol = 16'h382A;
      8'h46: f_symbol = 16'h3928; 8'h45: f_symbol = 16'h3029; 8'h4E: f_symbol = 16'h2D5F;
      8'h55: f_symbol = 16'h3D2B; 8'h54: f_symbol = 16'h5B7B; 8'h5B: f_symbol = 16'h5D7D;
      8'h5D: f_symbol = 16'h5C7C; 8'h4C: f_symbol = 16'h3B3A; 8'h52: f_symbol = 16'h2722;
      8'h41: f_symbol = 16'h2C3C; 8'h49: f_symbol = 16'h2E3E; 8'h4A: f_symbol = 16'h2F3F;
      8'h29: f_symbol = 16'h2020; 8'h5A: f_symbol = 16'h0D0D; 8'h66: f_symbol = 16'h0808;
      8'h0D: f_symbol = 16'h0909; 8'h76: f_symbol = 16'h1B1B;
      default: f_symbol = 16'h0000;
    endcase
  endfunction

  assign w_shift   = r_lshift | r_rshift;
  assign w_ctrl    = r_lctrl | r_rctrl;
  assign w_alt     = r_lalt | r_ralt;
  assign w_can_pop = bus.kb_ready & (~r_key_valid | bus.key_ack);
  assign w_letter  = f_letter(bus.kb_data);
  assign w_sym     = f_symbol(bus.kb_data);

  always_comb begin
    w_ascii = 8'h00;
    if (!r_pend_ext && !r_pend_brk) begin
      if (w_letter != 8'h00) begin
        if (w_ctrl)                w_ascii = w_letter - 8'h60;
        else if (w_shift ^ r_caps) w_ascii = w_letter - 8'h20;
        else                       w_ascii = w_letter;
      end else begin
        w_ascii = w_shift ? w_sym[7:0] : w_sym[15:8];
      end
    end
  end

`ifdef CAPS_LED_EN
  logic [23:0] r_to_cnt;
  logic [7:0]  r_senddata;
  logic        w_caps_make, w_in_wait;

  assign w_caps_make = (bus.kb_data == 8'h58) & ~r_pend_ext & ~r_pend_brk & ~r_caps_down;
  assign w_in_wait   = (r_state == LED_WAIT1) || (r_state == LED_WAIT2);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_event     = 1'b0;
    w_set_brk   = 1'b0;
    w_set_ext   = 1'b0;
    w_clr_pend  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_can_pop) begin
          w_pop = 1'b1;
          case (bus.kb_data)
            8'hF0: w_set_brk = 1'b1;
            8'hE0: w_set_ext = 1'b1;
            8'hE1: begin
              w_clr_pend  = 1'b1;
              w_state_nxt = SKIP_E1;
            end
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: w_clr_pend = 1'b1;
            default: begin
              w_event    = 1'b1;
              w_clr_pend = 1'b1;
`ifdef CAPS_LED_EN
              if (w_caps_make) w_state_nxt = LED_CMD;
`endif
            end
          endcase
        end
      end
      SKIP_E1: begin
        if (w_can_pop) begin
          w_pop = 1'b1;
          if (r_skip_cnt == 3'd6) w_state_nxt = IDLE;
        end
      end
`ifdef CAPS_LED_EN
      LED_CMD:  w_state_nxt = LED_WAIT1;
      LED_DATA: w_state_nxt = LED_WAIT2;
      LED_WAIT1, LED_WAIT2: begin
        // Wait-state pops bypass the event register: the reply byte never becomes an event
        if (bus.kb_ready) begin
          w_pop = 1'b1;
          if (bus.kb_data == 8'hFA) w_state_nxt = (r_state == LED_WAIT1) ? LED_DATA : IDLE;
          else                      w_state_nxt = IDLE;
        end else if (r_to_cnt == ACK_TIMEOUT) begin
          w_state_nxt = IDLE;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pend_brk  <= 1'b0;
      r_pend_ext  <= 1'b0;
      r_skip_cnt  <= 3'd0;
      r_key_valid <= 1'b0;
      r_key_code  <= 8'h00;
      r_key_ext   <= 1'b0;
      r_key_break <= 1'b0;
      r_key_ascii <= 8'h00;
      r_lshift    <= 1'b0;
      r_rshift    <= 1'b0;
      r_lctrl     <= 1'b0;
      r_rctrl     <= 1'b0;
      r_lalt      <= 1'b0;
      r_ralt      <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_down <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr_pend) begin
        r_pend_brk <= 1'b0;
        r_pend_ext <= 1'b0;
      end else begin
        if (w_set_brk) r_pend_brk <= 1'b1;
        if (w_set_ext) r_pend_ext <= 1'b1;
      end
      if (r_state != SKIP_E1) r_skip_cnt <= 3'd0;
      else if (w_pop)         r_skip_cnt <= r_skip_cnt + 3'd1;
      if (w_event) begin
        r_key_valid <= 1'b1;
        r_key_code  <= bus.kb_data;
        r_key_ext   <= r_pend_ext;
        r_key_break <= r_pend_brk;
        r_key_ascii <= w_ascii;
      end else if (bus.key_ack) begin
        r_key_valid <= 1'b0;
      end
      if (w_event && !r_pend_ext) begin
        case (bus.kb_data)
          8'h12: r_lshift <= ~r_pend_brk;
          8'h59: r_rshift <= ~r_pend_brk;
          8'h14: r_lctrl  <= ~r_pend_brk;
          8'h11: r_lalt   <= ~r_pend_brk;
          8'h58: begin
            // Latch blocks typematic repeats from toggling until the key is released
            if (r_pend_brk) begin
              r_caps_down <= 1'b0;
            end else if (!r_caps_down) begin
              r_caps      <= ~r_caps;
              r_caps_down <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (w_event && r_pend_ext) begin
        if (bus.kb_data == 8'h14) r_rctrl <= ~r_pend_brk;
        if (bus.kb_data == 8'h11) r_ralt  <= ~r_pend_brk;
      end
    end
  end

`ifdef CAPS_LED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt   <= 24'd0;
      r_senddata <= 8'h00;
    end else begin
      if (w_in_wait && (w_state_nxt == r_state)) r_to_cnt <= r_to_cnt + 24'd1;
      else                                       r_to_cnt <= 24'd0;
      if (r_state != LED_CMD && w_state_nxt == LED_CMD)   r_senddata <= 8'hED;
      if (r_state != LED_DATA && w_state_nxt == LED_DATA) r_senddata <= {5'b0, r_caps, 2'b0};
    end
  end

  assign bus.kb_send     = (r_state == LED_CMD) || (r_state == LED_DATA);
  assign bus.kb_senddata = r_senddata;
`else
  assign bus.kb_send     = 1'b0;
  assign bus.kb_senddata = 8'h00;
`endif

  assign bus.kb_read   = w_pop;
  assign bus.key_valid = r_key_valid;
  assign bus.key_code  = r_key_code;
  assign bus.key_ext   = r_key_ext;
  assign bus.key_break = r_key_break;
  assign bus.key_ascii = r_key_ascii;
  assign bus.shift     = w_shift;
  assign bus.ctrl      = w_ctrl;
  assign bus.alt       = w_alt;
  assign bus.caps      = r_caps;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: FIFO model feeds bytes, expected events are queued
// as bytes are fed and compared (with modifier state) when the event is acknowledged.
module tb_ps2_scancode_decoder;
  localparam logic [23:0] TB_TIMEOUT = 24'd40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_scancode_decoder_if bus();

`ifdef CAPS_LED_EN
  ps2_scancode_decoder #(.ACK_TIMEOUT(TB_TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  ps2_scancode_decoder dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
    logic       sh;
    logic       ct;
    logic       al;
    logic       cp;
  } ev_t;

  ev_t        sb[$];
  logic [7:0] fifo[$];
  logic [7:0] sends[$];
  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;
  int n_events = 0;
  int ack_mode = 1;  // 0 never ack, 1 ack every event, 2 ack one event then stop

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ev(input logic [7:0] c, input logic e, input logic b, input logic [7:0] a,
                    input logic sh, input logic ct, input logic al, input logic cp);
    ev_t x;
    x.code = c; x.ext = e; x.brk = b; x.ascii = a;
    x.sh = sh; x.ct = ct; x.al = al; x.cp = cp;
    sb.push_back(x);
  endtask

  // bytes are given first-byte-most-significant
  task automatic feed(input int n, input logic [63:0] bytes);
    for (int i = n - 1; i >= 0; i--) fifo.push_back(bytes[i*8 +: 8]);
  endtask

  task automatic check_event();
    ev_t o, x;
    o.code = bus.key_code; o.ext = bus.key_ext; o.brk = bus.key_break; o.ascii = bus.key_ascii;
    o.sh = bus.shift; o.ct = bus.ctrl; o.al = bus.alt; o.cp = bus.caps;
    n_events++;
    n_checks++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL unexpected_event: got %0h expected no event", o);
    end
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk($sformatf("event_%0d", n_events), 64'(o), 64'(x));
    end
  endtask

  task automatic tick();
    logic [7:0] tmp;
    @(negedge clk);
    bus.kb_ready = (fifo.size() != 0);
    bus.kb_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    bus.key_ack  = (ack_mode != 0) && bus.key_valid;
    if (ack_mode == 2 && bus.key_valid) ack_mode = 0;
    #1;
    if (bus.kb_read && bus.kb_ready) begin
      tmp = fifo.pop_front();
      pops++;
    end
    if (bus.kb_send) sends.push_back(bus.kb_senddata);
    if (bus.key_valid && bus.key_ack) check_event();
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((fifo.size() != 0 || bus.key_valid) && guard < 400) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    chk({tag, "_drained"}, 64'(guard < 400), 64'd1);
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int e0, p0;
    rst = 1'b1;
    bus.kb_ready = 1'b0;
    bus.kb_data  = 8'h00;
    bus.key_ack  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_key_valid", 64'(bus.key_valid), 64'd0);
    chk("rst_key_fields", 64'({bus.key_code, bus.key_ext, bus.key_break, bus.key_ascii}), 64'd0);
    chk("rst_modifiers", 64'({bus.shift, bus.ctrl, bus.alt, bus.caps}), 64'd0);
    chk("rst_kb_read", 64'(bus.kb_read), 64'd0);
    chk("rst_send", 64'({bus.kb_send, bus.kb_senddata}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // make and break of 'a'
    e0 = n_events;
    feed(3, 24'h1C_F01C);
    ev(8'h1C, 0, 0, 8'h61, 0, 0, 0, 0);
    ev(8'h1C, 0, 1, 8'h00, 0, 0, 0, 0);
    drain("t1");
    chk("t1_event_count", 64'(n_events - e0), 64'd2);

    // shift held around 'a'
    feed(5, 40'h12_1C_F0_12_1C);
    ev(8'h12, 0, 0, 8'h00, 1, 0, 0, 0);
    ev(8'h1C, 0, 0, 8'h41, 1, 0, 0, 0);
    ev(8'h12, 0, 1, 8'h00, 0, 0, 0, 0);
    ev(8'h1C, 0, 0, 8'h61, 0, 0, 0, 0);
    drain("t2");

    // caps toggle, typematic repeat, release, then caps^shift; FA bytes answer the LED update when enabled
    sends.delete();
    feed(3, 24'h58_FA_FA);
    feed(5, 40'h58_F0_58_1C_12);
    feed(4, 32'h1C_F0_12_00);
    ev(8'h58, 0, 0, 8'h00, 0, 0, 0, 1);
    ev(8'h58, 0, 0, 8'h00, 0, 0, 0, 1);
    ev(8'h58, 0, 1, 8'h00, 0, 0, 0, 1);
    ev(8'h1C, 0, 0, 8'h41, 0, 0, 0, 1);
    ev(8'h12, 0, 0, 8'h00, 1, 0, 0, 1);
    ev(8'h1C, 0, 0, 8'h61, 1, 0, 0, 1);
    ev(8'h12, 0, 1, 8'h00, 0, 0, 0, 1);
    drain("t3");
`ifdef CAPS_LED_EN
    chk("t3_send_count", 64'(sends.size()), 64'd2);
    if (sends.size() >= 2) begin
      chk("t3_send_cmd", 64'(sends[0]), 64'hED);
      chk("t3_send_led", 64'(sends[1]), 64'h04);
    end
`else
    chk("t3_no_send", 64'(sends.size()), 64'd0);
`endif

    // extended key, then a full E1 pause sequence swallowed without events
    e0 = n_events;
    feed(2, 16'hE0_75);
    feed(8, 64'hE1_14_77_E1_F0_14_F0_77);
    feed(1, 8'h1C);
    ev(8'h75, 1, 0, 8'h00, 0, 0, 0, 1);
    ev(8'h1C, 0, 0, 8'h41, 0, 0, 0, 1);
    drain("t4");
    chk("t4_event_count", 64'(n_events - e0), 64'd2);

    // backpressure: no pops while the event is unacknowledged
    ack_mode = 0;
    p0 = pops;
    feed(4, 32'h1C_32_21_23);
    ev(8'h1C, 0, 0, 8'h41, 0, 0, 0, 1);
    ev(8'h32, 0, 0, 8'h42, 0, 0, 0, 1);
    ev(8'h21, 0, 0, 8'h43, 0, 0, 0, 1);
    ev(8'h23, 0, 0, 8'h44, 0, 0, 0, 1);
    repeat (10) tick();
    chk("bp_one_pop", 64'(pops - p0), 64'd1);
    chk("bp_valid_held", 64'(bus.key_valid), 64'd1);
    ack_mode = 2;
    repeat (10) tick();
    chk("bp_ack_one_pop", 64'(pops - p0), 64'd2);
    ack_mode = 2;
    repeat (10) tick();
    chk("bp_ack_two_pops", 64'(pops - p0), 64'd3);
    ack_mode = 1;
    drain("t5");

    // ctrl letter, right alt, shifted digit, discarded AA, specials, unmapped
    feed(8, 64'h14_1C_F0_14_E0_11_E0_F0);
    feed(8, 64'h11_12_16_F0_12_16_AA_29);
    feed(3, 24'h5A_05_4E);
    ev(8'h14, 0, 0, 8'h00, 0, 1, 0, 1);
    ev(8'h1C, 0, 0, 8'h01, 0, 1, 0, 1);
    ev(8'h14, 0, 1, 8'h00, 0, 0, 0, 1);
    ev(8'h11, 1, 0, 8'h00, 0, 0, 1, 1);
    ev(8'h11, 1, 1, 8'h00, 0, 0, 0, 1);
    ev(8'h12, 0, 0, 8'h00, 1, 0, 0, 1);
    ev(8'h16, 0, 0, 8'h21, 1, 0, 0, 1);
    ev(8'h12, 0, 1, 8'h00, 0, 0, 0, 1);
    ev(8'h16, 0, 0, 8'h31, 0, 0, 0, 1);
    ev(8'h29, 0, 0, 8'h20, 0, 0, 0, 1);
    ev(8'h5A, 0, 0, 8'h0D, 0, 0, 0, 1);
    ev(8'h05, 0, 0, 8'h00, 0, 0, 0, 1);
    ev(8'h4E, 0, 0, 8'h2D, 0, 0, 0, 1);
    drain("t6");

    // reset with shift down and a break prefix pending
    feed(2, 16'h12_F0);
    ev(8'h12, 0, 0, 8'h00, 1, 0, 0, 1);
    repeat (6) tick();
    chk("t7_prefix_popped", 64'(fifo.size()), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t7_rst_modifiers", 64'({bus.shift, bus.ctrl, bus.alt, bus.caps}), 64'd0);
    chk("t7_rst_valid", 64'(bus.key_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    feed(1, 8'h1C);
    ev(8'h1C, 0, 0, 8'h61, 0, 0, 0, 0);
    drain("t7");

`ifdef CAPS_LED_EN
    // LED update with no keyboard reply must abort without a second send
    sends.delete();
    feed(1, 8'h58);
    ev(8'h58, 0, 0, 8'h00, 0, 0, 0, 1);
    repeat (int'(TB_TIMEOUT) + 30) tick();
    chk("t8_send_count", 64'(sends.size()), 64'd1);
    if (sends.size() >= 1) chk("t8_send_cmd", 64'(sends[0]), 64'hED);
    feed(1, 8'h1C);
    ev(8'h1C, 0, 0, 8'h41, 0, 0, 0, 1);
    drain("t8");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
